mt_stream_pkt_fifo: RTL

Packet-aware, parametrised stream buffer for the MT stream fabric (data/valid/last/ready), inserted between the RMQ TX/RX path blocks and their stream sources/sinks. It decouples producer and consumer throttling and tracks word and packet occupancy. Optionally it buffers whole packets before release (store-and-forward) and supports aborting a packet in flight.

---
 rtl/mt_stream_pkt_fifo.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mt_stream_pkt_fifo.sv
// ============================================================================
// Module   : mt_stream_pkt_fifo
// Purpose  : Packet-aware stream buffer for the MT stream fabric. Decouples
//            producer and consumer throttling and reports word and packet
//            occupancy. Optionally holds whole packets until their last word
//            arrives (store-and-forward) and can abort a packet in flight.
// Config   : define MT_STREAM_PKT_FIFO_SNF_EN to build the store-and-forward
//            variant; left undefined the buffer is cut-through.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            snk_*               - input stream (data/valid/last/drop/ready)
//            src_*               - output stream (data/valid/last/ready)
//            level_o             - words held, output register included
//            pkt_count_o         - complete packets held
//            forced_o            - one-cycle pulse on a forced commit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mt_stream_pkt_fifo #(
  parameter int g_data_width = 32,
  parameter int g_addr_width = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_data_width-1:0] snk_data_i,
  input  logic                    snk_valid_i,
  input  logic                    snk_last_i,
  input  logic                    snk_drop_i,
  output logic                    snk_ready_o,
  output logic [g_data_width-1:0] src_data_o,
  output logic                    src_valid_o,
  output logic                    src_last_o,
  input  logic                    src_ready_i,
  output logic [g_addr_width:0]   level_o,
  output logic [g_addr_width:0]   pkt_count_o,
  output logic                    forced_o
);

  localparam int                c_depth    = 1 << g_addr_width;
  localparam int                c_pw       = g_addr_width + 1;
  localparam logic [c_pw-1:0]   c_ptr_one  = c_pw'(1);
  localparam logic [c_pw-1:0]   c_depth_lv = c_pw'(c_depth);

  // Storage: each entry is {last, data}.
  logic [g_data_width:0] mem_q [c_depth];

  logic [c_pw-1:0] wp_q, wp_d;
  logic [c_pw-1:0] rp_q;
  logic [c_pw-1:0] cp_q, cp_d;
  logic [c_pw-1:0] level_q, level_d;
  logic [c_pw-1:0] pkt_q, pkt_d;
  logic [c_pw-1:0] w_limit;

  // RAM read stage, then the first-word-fall-through output register.
  logic                    a_valid_q;
  logic                    a_last_q;
  logic [g_data_width-1:0] a_data_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [g_data_width-1:0] out_data_q;

  logic w_full;
  logic w_wr;
  logic w_pop;
  logic w_out_load;
  logic w_a_load;

  // Full is taken from the total word count so that the words sitting in the
  // read stage and output register count against the capacity of D words.
  assign w_full      = (level_q == c_depth_lv);
  assign snk_ready_o = !w_full;
  assign w_wr        = snk_valid_i && !w_full;
  assign w_pop       = out_valid_q && src_ready_i;
  assign w_out_load  = a_valid_q && (!out_valid_q || src_ready_i);
  assign w_a_load    = (!a_valid_q || w_out_load) && (rp_q != w_limit);

  assign src_data_o  = out_data_q;
  assign src_valid_o = out_valid_q;
  assign src_last_o  = out_last_q;
  assign level_o     = level_q;
  assign pkt_count_o = pkt_q;

  // --------------------------------------------------------------------------
  // Commit pointer control
  // --------------------------------------------------------------------------
`ifdef MT_STREAM_PKT_FIFO_SNF_EN
  logic forced_q, forced_d;
  logic forced_pulse_q;
  logic w_force;

  // The read side stops at the commit pointer.
  assign w_limit  = cp_q;
  assign forced_o = forced_pulse_q;

  // A packet that fills the whole buffer with nothing committed ahead of it
  // can never complete; commit what is there and stream the rest through.
  assign w_force = w_full && (cp_q == rp_q) && (wp_q != cp_q) && !forced_q;

  always_comb begin
    wp_d     = wp_q;
    cp_d     = cp_q;
    forced_d = forced_q;
    level_d  = level_q + {{g_addr_width{1'b0}}, w_wr}
                       - {{g_addr_width{1'b0}}, w_pop};
    pkt_d    = pkt_q + {{g_addr_width{1'b0}}, (w_wr && snk_last_i)}
                     - {{g_addr_width{1'b0}}, (w_pop && out_last_q)};
    if (w_wr) begin
      wp_d = wp_q + c_ptr_one;
    end

    if (snk_drop_i) begin
      // Rewind to the last commit point; a word written this cycle is lost
      // too, so it contributes to neither count.
      wp_d     = cp_q;
      forced_d = 1'b0;
      level_d  = level_q - (wp_q - cp_q) - {{g_addr_width{1'b0}}, w_pop};
      pkt_d    = pkt_q - {{g_addr_width{1'b0}}, (w_pop && out_last_q)};
    end else if (w_force) begin
      cp_d     = wp_q;
      forced_d = 1'b1;
    end else if (w_wr && (snk_last_i || forced_q)) begin
      // While a forced packet is streaming every word is committed at once.
      cp_d = wp_q + c_ptr_one;
      if (snk_last_i) begin
        forced_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      forced_q       <= 1'b0;
      forced_pulse_q <= 1'b0;
    end else begin
      forced_q       <= forced_d;
      forced_pulse_q <= w_force;
    end
  end
`else
  logic unused_drop;

  // Cut-through: everything written is immediately readable.
  assign w_limit     = wp_q;
  assign forced_o    = 1'b0;
  assign unused_drop = snk_drop_i;

  always_comb begin
    wp_d    = wp_q;
    level_d = level_q + {{g_addr_width{1'b0}}, w_wr}
                      - {{g_addr_width{1'b0}}, w_pop};
    pkt_d   = pkt_q + {{g_addr_width{1'b0}}, (w_wr && snk_last_i)}
                    - {{g_addr_width{1'b0}}, (w_pop && out_last_q)};
    if (w_wr) begin
      wp_d = wp_q + c_ptr_one;
    end
    cp_d = wp_d;
  end
`endif

  // --------------------------------------------------------------------------
  // Storage array and its registered read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      mem_q[wp_q[g_addr_width-1:0]] <= {snk_last_i, snk_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_a_load) begin
      {a_last_q, a_data_q} <= mem_q[rp_q[g_addr_width-1:0]];
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, counters and pipeline valids
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cp_q        <= '0;
      level_q     <= '0;
      pkt_q       <= '0;
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      cp_q    <= cp_d;
      level_q <= level_d;
      pkt_q   <= pkt_d;

      if (w_a_load) begin
        rp_q      <= rp_q + c_ptr_one;
        a_valid_q <= 1'b1;
      end else if (w_out_load) begin
        a_valid_q <= 1'b0;
      end

      if (w_out_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= a_data_q;
        out_last_q  <= a_last_q;
      end else if (w_pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
